// File: rtl/count_pkg.sv
// Shared types and constants for the decimal counter stream and its receive-side tracker.
package count_pkg;
  localparam int CNT_W           = 4;
  localparam int CNT_MOD_DEFAULT = 10;

  typedef enum logic {ACQ = 1'b0, LOCK = 1'b1} trk_state_t;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DN   = 2'd1,
    STEP_HOLD = 2'd2,
    STEP_ILL  = 2'd3
  } step_t;
endpackage

// File: rtl/count_step_decode.sv
// Combinational classifier of one counter step (prev -> cur) modulo CNT_MOD,
// with qualifiers marking the wrap-around steps.
module count_step_decode
  import count_pkg::*;
#(
  parameter int CNT_MOD = CNT_MOD_DEFAULT
) (
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] cur,
  output step_t            step,
  output logic             wrap_up,
  output logic             wrap_dn
);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MOD - 1);

  logic [CNT_W-1:0] up_v;
  logic [CNT_W-1:0] dn_v;

  always_comb begin
    up_v    = (prev == MAX_V) ? '0 : prev + CNT_W'(1);
    dn_v    = (prev == '0) ? MAX_V : prev - CNT_W'(1);
    step    = STEP_ILL;
    wrap_up = 1'b0;
    wrap_dn = 1'b0;
    // A step out of an out-of-range value has no modular meaning: illegal.
    if (prev > MAX_V) begin
      step = STEP_ILL;
    end else if (cur == prev) begin
      step = STEP_HOLD;
    end else if (cur == up_v) begin
      step    = STEP_UP;
      wrap_up = (prev == MAX_V);
    end else if (cur == dn_v) begin
      step    = STEP_DN;
      wrap_dn = (prev == '0);
    end
  end
endmodule

// File: rtl/count_tracker.sv
// Receive-side monitor for the decimal up/down counter stream; all outputs registered.
// Optional signed net-position accumulator enabled by COUNT_TRACKER_NET_POS_EN.
module count_tracker
  import count_pkg::*;
#(
  parameter int CNT_MOD = CNT_MOD_DEFAULT,
  parameter int WRAP_W  = 8,
  parameter int POS_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [CNT_W-1:0]  number,
  input  logic              zero,
  output logic              locked,
  output logic              dir,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [WRAP_W-1:0] wrap_up_cnt,
  output logic [WRAP_W-1:0] wrap_dn_cnt,
  output logic              step_err,
  output logic              zero_err,
  output logic              range_err,
  output logic [POS_W-1:0]  net_pos
);
  localparam logic [CNT_W:0] MOD_V = (CNT_W + 1)'(CNT_MOD);

  trk_state_t       state_q, state_d;
  logic [CNT_W-1:0] prev_q;
  step_t            step;
  logic             dec_wrap_up, dec_wrap_dn;
  logic             out_of_range, move_up, move_dn;
  logic             locked_d, dir_d, wrap_up_d, wrap_dn_d;
  logic             step_err_d, zero_err_d;
  logic [WRAP_W-1:0] wrap_up_cnt_d, wrap_dn_cnt_d;

  count_step_decode #(.CNT_MOD(CNT_MOD)) u_decode (
    .prev    (prev_q),
    .cur     (number),
    .step    (step),
    .wrap_up (dec_wrap_up),
    .wrap_dn (dec_wrap_dn)
  );

  always_comb begin
    state_d      = state_q;
    locked_d     = locked;
    dir_d        = dir;
    wrap_up_d    = 1'b0;
    wrap_dn_d    = 1'b0;
    step_err_d   = 1'b0;
    out_of_range = ({1'b0, number} >= MOD_V);
    move_up      = 1'b0;
    move_dn      = 1'b0;
    zero_err_d   = (state_q == LOCK) && (zero != (number == '0));

    if (out_of_range) begin
      // Range violation outranks step checking and always drops lock.
      state_d  = ACQ;
      locked_d = 1'b0;
      dir_d    = 1'b0;
    end else if (state_q == ACQ) begin
      if (step == STEP_UP || step == STEP_DN) begin
        state_d  = LOCK;
        locked_d = 1'b1;
        dir_d    = (step == STEP_UP);
      end
    end else begin
      if (step == STEP_UP || step == STEP_DN) begin
        move_up   = (step == STEP_UP);
        move_dn   = (step == STEP_DN);
        dir_d     = move_up;
        wrap_up_d = dec_wrap_up;
        wrap_dn_d = dec_wrap_dn;
      end else begin
        step_err_d = 1'b1;
        state_d    = ACQ;
        locked_d   = 1'b0;
        dir_d      = 1'b0;
      end
    end

    wrap_up_cnt_d = wrap_up_cnt;
    wrap_dn_cnt_d = wrap_dn_cnt;
    if (clr) begin
      wrap_up_cnt_d = '0;
      wrap_dn_cnt_d = '0;
    end else begin
      if (wrap_up_d && (wrap_up_cnt != '1)) wrap_up_cnt_d = wrap_up_cnt + WRAP_W'(1);
      if (wrap_dn_d && (wrap_dn_cnt != '1)) wrap_dn_cnt_d = wrap_dn_cnt + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACQ;
      prev_q      <= '0;
      locked      <= 1'b0;
      dir         <= 1'b0;
      wrap_up     <= 1'b0;
      wrap_dn     <= 1'b0;
      wrap_up_cnt <= '0;
      wrap_dn_cnt <= '0;
      step_err    <= 1'b0;
      zero_err    <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= number;
      locked      <= locked_d;
      dir         <= dir_d;
      wrap_up     <= wrap_up_d;
      wrap_dn     <= wrap_dn_d;
      wrap_up_cnt <= wrap_up_cnt_d;
      wrap_dn_cnt <= wrap_dn_cnt_d;
      step_err    <= step_err_d;
      zero_err    <= zero_err_d;
      range_err   <= out_of_range;
    end
  end

`ifdef COUNT_TRACKER_NET_POS_EN
  logic [POS_W-1:0] net_pos_d;

  always_comb begin
    net_pos_d = net_pos;
    if (clr)          net_pos_d = '0;
    else if (move_up) net_pos_d = net_pos + POS_W'(1);
    else if (move_dn) net_pos_d = net_pos - POS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) net_pos <= '0;
    else        net_pos <= net_pos_d;
  end
`else
  logic unused_move;
  assign unused_move = move_up ^ move_dn;
  assign net_pos     = '0;
`endif
endmodule

// File: tb/tb_count_tracker.sv
// Bench for count_tracker: directed scenarios then a random walk, checked against
// a modular-arithmetic reference model; second instance uses WRAP_W=2 for saturation.
module tb_count_tracker;
  localparam int MOD = 10;

  logic        clk, rst_n, clr, zero;
  logic [3:0]  number;

  logic        locked, dir, wrap_up, wrap_dn, step_err, zero_err, range_err;
  logic [7:0]  wrap_up_cnt, wrap_dn_cnt;
  logic [11:0] net_pos;

  logic        d2_locked, d2_dir, d2_wrap_up, d2_wrap_dn, d2_step_err, d2_zero_err, d2_range_err;
  logic [1:0]  d2_wrap_up_cnt, d2_wrap_dn_cnt;
  logic [11:0] d2_net_pos;

  count_tracker #(.CNT_MOD(MOD), .WRAP_W(8), .POS_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .number(number), .zero(zero),
    .locked(locked), .dir(dir), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
    .wrap_up_cnt(wrap_up_cnt), .wrap_dn_cnt(wrap_dn_cnt),
    .step_err(step_err), .zero_err(zero_err), .range_err(range_err), .net_pos(net_pos)
  );

  count_tracker #(.CNT_MOD(MOD), .WRAP_W(2), .POS_W(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .number(number), .zero(zero),
    .locked(d2_locked), .dir(d2_dir), .wrap_up(d2_wrap_up), .wrap_dn(d2_wrap_dn),
    .wrap_up_cnt(d2_wrap_up_cnt), .wrap_dn_cnt(d2_wrap_dn_cnt),
    .step_err(d2_step_err), .zero_err(d2_zero_err), .range_err(d2_range_err),
    .net_pos(d2_net_pos)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_prev, m_up_cnt, m_dn_cnt, m_pos;
  bit m_locked, m_dir, m_wrap_up, m_wrap_dn, m_step_err, m_zero_err, m_range_err;

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    m_prev = 0; m_up_cnt = 0; m_dn_cnt = 0; m_pos = 0;
    m_locked = 0; m_dir = 0; m_wrap_up = 0; m_wrap_dn = 0;
    m_step_err = 0; m_zero_err = 0; m_range_err = 0;
  endtask

  task automatic model_step(input int n, input bit z, input bit c);
    int  d;
    bit  is_up, is_dn, legal;
    is_up = 0; is_dn = 0;
    if (m_prev < MOD && n < MOD) begin
      d = (n - m_prev + MOD) % MOD;
      is_up = (d == 1);
      is_dn = !is_up && (d == MOD - 1);
    end
    legal       = is_up || is_dn;
    m_zero_err  = m_locked && (z != (n == 0));
    m_range_err = (n >= MOD);
    m_step_err  = 0;
    m_wrap_up   = 0;
    m_wrap_dn   = 0;
    if (m_range_err) begin
      m_locked = 0; m_dir = 0;
    end else if (!m_locked) begin
      if (legal) begin m_locked = 1; m_dir = is_up; end
    end else if (legal) begin
      m_dir     = is_up;
      m_wrap_up = is_up && (n == 0);
      m_wrap_dn = is_dn && (n == MOD - 1);
      if (!c) m_pos += is_up ? 1 : -1;
    end else begin
      m_step_err = 1; m_locked = 0; m_dir = 0;
    end
    if (c) begin
      m_up_cnt = 0; m_dn_cnt = 0; m_pos = 0;
    end else begin
      m_up_cnt += int'(m_wrap_up);
      m_dn_cnt += int'(m_wrap_dn);
    end
    m_prev = n;
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [11:0] e_pos;
`ifdef COUNT_TRACKER_NET_POS_EN
    e_pos = m_pos[11:0];
`else
    e_pos = '0;
`endif
    chk({tag, ".locked"},    32'(locked),      32'(m_locked));
    chk({tag, ".dir"},       32'(dir),         32'(m_dir));
    chk({tag, ".wrap_up"},   32'(wrap_up),     32'(m_wrap_up));
    chk({tag, ".wrap_dn"},   32'(wrap_dn),     32'(m_wrap_dn));
    chk({tag, ".up_cnt"},    32'(wrap_up_cnt), 32'(sat(m_up_cnt, 8)));
    chk({tag, ".dn_cnt"},    32'(wrap_dn_cnt), 32'(sat(m_dn_cnt, 8)));
    chk({tag, ".step_err"},  32'(step_err),    32'(m_step_err));
    chk({tag, ".zero_err"},  32'(zero_err),    32'(m_zero_err));
    chk({tag, ".range_err"}, 32'(range_err),   32'(m_range_err));
    chk({tag, ".net_pos"},   32'(net_pos),     32'(e_pos));
    chk({tag, ".d2_locked"}, 32'(d2_locked),   32'(m_locked));
    chk({tag, ".d2_dir"},    32'(d2_dir),      32'(m_dir));
    chk({tag, ".d2_wup"},    32'(d2_wrap_up),  32'(m_wrap_up));
    chk({tag, ".d2_wdn"},    32'(d2_wrap_dn),  32'(m_wrap_dn));
    chk({tag, ".d2_up_cnt"}, 32'(d2_wrap_up_cnt), 32'(sat(m_up_cnt, 2)));
    chk({tag, ".d2_dn_cnt"}, 32'(d2_wrap_dn_cnt), 32'(sat(m_dn_cnt, 2)));
    chk({tag, ".d2_serr"},   32'(d2_step_err), 32'(m_step_err));
    chk({tag, ".d2_zerr"},   32'(d2_zero_err), 32'(m_zero_err));
    chk({tag, ".d2_rerr"},   32'(d2_range_err), 32'(m_range_err));
    chk({tag, ".d2_pos"},    32'(d2_net_pos),  32'(e_pos));
  endtask

  // Driver: present a sample, let the edge take it, then compare #1 later.
  task automatic cyc(input string tag, input int n, input bit z, input bit c);
    number = 4'(n);
    zero   = z;
    clr    = c;
    @(posedge clk);
    model_step(n, z, c);
    #1;
    check_all(tag);
    clr = 1'b0;
  endtask

  task automatic cz(input string tag, input int n);
    cyc(tag, n, (n == 0), 1'b0);
  endtask

  initial begin
    int cur, nv, r;
    bit z, c;

    rst_n = 1'b0; clr = 1'b0; number = '0; zero = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 rst_n = 1'b1;

    // 1: count up through two wraps
    cz("t1", 0);
    cz("t1", 0);
    cz("t1", 1);
    chk("t1_lock_after_1", 32'(locked), 32'd1);
    for (int v = 2; v <= 9; v++) cz("t1", v);
    for (int v = 0; v <= 9; v++) cz("t1", v);
    cz("t1", 0);
    cz("t1", 1);
    chk("t1_wrap_up_cnt", 32'(wrap_up_cnt), 32'd2);

    // 2: direction reversals
    cz("t2", 2);
    cz("t2", 3);
    cz("t2", 4); chk("t2_dir_a", 32'(dir), 32'd1);
    cz("t2", 3); chk("t2_dir_b", 32'(dir), 32'd0);
    cz("t2", 2); chk("t2_dir_c", 32'(dir), 32'd0);
    cz("t2", 3); chk("t2_dir_d", 32'(dir), 32'd1);

    // 3: illegal step then relock
    cz("t3", 4);
    cz("t3", 7);
    chk("t3_step_err", 32'(step_err), 32'd1);
    chk("t3_unlocked", 32'(locked), 32'd0);
    cz("t3", 8);
    chk("t3_relock", 32'(locked), 32'd1);

    // 4: zero flag mismatches
    cz("t4", 9);
    cyc("t4", 0, 1'b0, 1'b0);
    chk("t4_zero_err_a", 32'(zero_err), 32'd1);
    for (int v = 1; v <= 4; v++) cz("t4", v);
    cyc("t4", 5, 1'b1, 1'b0);
    chk("t4_zero_err_b", 32'(zero_err), 32'd1);
    chk("t4_still_locked", 32'(locked), 32'd1);

    // 5: out of range, then wrap-counter saturation on the narrow instance
    cz("t5", 12);
    chk("t5_range_err", 32'(range_err), 32'd1);
    chk("t5_no_step_err", 32'(step_err), 32'd0);
    cyc("t5", 0, 1'b1, 1'b1);
    for (int w = 0; w < 5; w++) begin
      for (int v = 1; v <= 9; v++) cz("t5", v);
      cz("t5", 0);
    end
    chk("t5_sat_cnt2", 32'(d2_wrap_up_cnt), 32'd3);
    chk("t5_cnt8", 32'(wrap_up_cnt), 32'd5);

    // 6: async reset between edges, relock, then clr against a wrap_dn pulse
    cz("t6", 1);
    cz("t6", 2);
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    check_all("t6_async_rst");
    #2 rst_n = 1'b1;
    cz("t6", 0);
    chk("t6_not_yet_locked", 32'(locked), 32'd0);
    cz("t6", 1);
    chk("t6_relocked", 32'(locked), 32'd1);
    cz("t6", 0);
    cyc("t6", 9, 1'b0, 1'b1);
    chk("t6_wrap_dn_pulse", 32'(wrap_dn), 32'd1);
    chk("t6_clr_wins", 32'(wrap_dn_cnt), 32'd0);

    // Random walk with occasional faults and clears
    cur = 9;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      nv = (cur + 1) % MOD;
      else if (r < 65) nv = (cur + MOD - 1) % MOD;
      else if (r < 75) nv = cur;
      else if (r < 90) nv = $urandom_range(0, MOD - 1);
      else             nv = $urandom_range(MOD, 15);
      z = (nv == 0);
      if ($urandom_range(0, 19) == 0) z = !z;
      c = ($urandom_range(0, 29) == 0);
      cyc("rnd", nv, z, c);
      cur = nv;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
